dcache_data_memory: RTL
=======================

# dcache_data_memory

Line-granular backing data memory that sits directly downstream of the data cache and serves its 256-bit miss and write-back traffic. A request is accepted on `enable_i`, held for a fixed, parameterised access latency by a counter-driven state machine, then completed with a one-cycle `ack_o` pulse. For reads the line is returned on `data_o`; for writes the line is committed to the array. This block is the memory model the cache controller's miss and write-back states handshake against.

## Interface
Parameters:
- `LATENCY`, 10, number of clock edges from request acceptance to `ack_o` assertion; legal range is 1..255.
- `DEPTH`, 512, number of 256-bit lines; must be a power of two. `IDX_W = $clog2(DEPTH)`.

Ports:
- `clk_i`, input, 1, single clock; all state updates on the rising edge.
- `rst_i`, input, 1, reset; asynchronous, active-high.
- `enable_i`, input, 1, request valid; held high by the requester until `ack_o`.
- `write_i`, input, 1, 1 = write line, 0 = read line.
- `addr_i`, input, 32, byte address of the line.
- `data_i`, input, 256, write line data.
- `data_o`, output, 256, read line data.
- `ack_o`, output, 1, one-cycle completion pulse.
- `err_o`, output, 1, address error flag; see Configuration.

## Operation
- Line index is `addr_i[5+IDX_W-1:5]`.
- `addr_i[4:0]` and bits above the index are ignored unless the address-check option is compiled in.
- States:
  - IDLE: if `enable_i` is high, latch `addr_i`, `write_i` and `data_i`, set `cnt` = 1, and go to WAIT. Otherwise stay in IDLE.
  - WAIT: if `enable_i` is low, abort: go to IDLE, no array access, no ack. Otherwise, if `cnt` == `LATENCY`, perform the access, set `ack_o` <= 1 and go to ACK. Otherwise `cnt` <= `cnt` + 1.
  - ACK: `ack_o` <= 0 and go to IDLE.
- An `enable_i` held high through ACK is re-sampled in IDLE as a new request. This allows write-back → refill back-to-back with `write_i` flipped.
- A spurious trailing read that is abandoned by deasserting `enable_i` is killed by the abort rule.
- `addr_i`, `data_i` and `write_i` changes during WAIT are ignored; the values latched in IDLE are used.
- Read access: `data_o` <= `mem[idx]`. `data_o` holds its value until the next completed read, and is not changed by writes.
- Write access: `mem[idx]` <= latched data, all 256 bits; there are no byte enables.
- `cnt` is 8 bits wide. It never wraps, because `LATENCY` ≤ 255.

## Timing
- Reset values: state IDLE, `cnt` 0, `ack_o` 0, `data_o` 0, `err_o` 0. Array contents are not reset.
- Reset asserted mid-request: the in-flight request is discarded, no write happens, and no ack is produced. After reset release, a still-high `enable_i` is accepted as a fresh request.
- Let E0 be the edge that accepts a request. `ack_o` rises at edge E0+`LATENCY+1`... more precisely at the edge where `cnt` == `LATENCY`, which is E0+`LATENCY`, and falls at E0+`LATENCY`+1.
- Read `data_o` becomes valid at the same edge `ack_o` rises.
- Minimum request-to-request spacing is `LATENCY`+2 edges. The next request is sampled in IDLE at E0+`LATENCY`+2 or later.
- The requester may sample `ack_o` on either clock edge. `ack_o` is stable for one full cycle.

## Configuration
- Macro: `DMEM_ADDR_CHECK_EN`.
- Defined:
  - At the access edge, an address error occurs if `addr_i[4:0]` != 0 or `addr_i[31:5]` ≥ `DEPTH`.
  - On error, `err_o` pulses together with `ack_o`, writes are dropped, and reads return `data_o` = 0.
  - Otherwise `err_o` stays 0.
- Undefined: `err_o` is tied to 0, addresses alias modulo `DEPTH` lines, and low bits are ignored.

## Test plan
- Reset, then read idx 0 with `LATENCY`=10 → `ack_o` high exactly 10 edges after acceptance, for 1 cycle; `data_o` = preload value.
- Write 0xA5…A5 at addr 0x00000040, then read 0x00000040 → read returns 0xA5…A5; `data_o` is unchanged after the write ack.
- Write-back then refill with `enable_i` held high and `write_i` 1→0 after the first ack → two acks spaced `LATENCY`+2 edges apart; the write lands before the read.
- Drop `enable_i` at `cnt`=5 during a write → no ack, and a later read shows the old line contents.
- Assert `rst_i` at `cnt`=3, release with `enable_i` high → the request restarts; ack arrives `LATENCY` edges after the post-reset accept edge.
- With `DMEM_ADDR_CHECK_EN` defined, read 0x00000044 → `err_o`=1 with `ack_o`, `data_o`=0. Without the macro, the same read returns the line at idx 2 and `err_o`=0.

Source files
------------

// File: rtl/dcache_data_memory.sv
// Line-granular 256-bit backing memory for the data cache. A request is
// accepted on enable_i and held for LATENCY edges. It then completes with a
// one-cycle ack_o pulse; reads return the line on data_o.
// Ports: clk_i, rst_i (async, active-high), enable_i, write_i, addr_i[31:0],
//        data_i[255:0], data_o[255:0], ack_o, err_o.
// Option: DMEM_ADDR_CHECK_EN flags misaligned or out-of-range addresses on err_o.
module dcache_data_memory #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic [255:0] data_o,
    output logic         ack_o,
    output logic         err_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    localparam logic [7:0] LAT8 = 8'(LATENCY);

    logic [255:0] mem [DEPTH];

    state_t       state;
    state_t       state_next;
    logic [7:0]   cnt;
    logic [7:0]   cnt_next;
    logic         ack_next;
    logic         latch;
    logic         access;

    logic         wr_q;
    logic [255:0] data_q;
    logic [IDX_W-1:0] idx;
    logic         addr_err;

`ifdef DMEM_ADDR_CHECK_EN
    logic [31:0]  addr_q;
    logic         err_q;

    assign idx      = addr_q[5+IDX_W-1:5];
    assign addr_err = (addr_q[4:0] != 5'd0) || (addr_q[31:5+IDX_W] != '0);
    assign err_o    = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access & addr_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else if (latch) begin
            addr_q <= addr_i;
        end
    end
`else
    // Without the check, offset bits and bits above the index are don't-care,
    // so addresses alias modulo DEPTH lines.
    logic [IDX_W-1:0] idx_q;
    logic             unused_addr;

    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};
    assign idx         = idx_q;
    assign addr_err    = 1'b0;
    assign err_o       = 1'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else if (latch) begin
            idx_q <= addr_i[5+IDX_W-1:5];
        end
    end
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ack_next   = 1'b0;
        latch      = 1'b0;
        access     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable_i) begin
                    latch      = 1'b1;
                    cnt_next   = 8'd1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Dropping enable_i mid-wait kills the request outright.
                if (!enable_i) begin
                    state_next = IDLE;
                end else if (cnt == LAT8) begin
                    access     = 1'b1;
                    ack_next   = 1'b1;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack_o <= ack_next;
            if (access && !wr_q) begin
                data_o <= addr_err ? '0 : mem[idx];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= 1'b0;
            data_q <= '0;
        end else if (latch) begin
            wr_q   <= write_i;
            data_q <= data_i;
        end
    end

    // Array is not reset; access is only ever high out of reset.
    always_ff @(posedge clk_i) begin
        if (access && wr_q && !addr_err) begin
            mem[idx] <= data_q;
        end
    end

endmodule
